axi_inst_rd_slave: RTL

- AXI3 read-channel responder (AR + R) serving instruction fetch requests from the dual-issue core's fetch port.
- Accepts one burst at a time and reads each beat from a synchronous instruction memory with 1-cycle read latency.
- Returns beats on R with ID, response and last-beat signalling.
- Sits between the core's AXI read master and the instruction RAM/ROM macro; replaces the testbench AXI model in simulation.

---
 rtl/axi_inst_rd_slave.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_inst_rd_slave.sv
// AXI3 read-only responder (AR + R) for instruction fetch, one burst at a time,
// backed by a synchronous instruction memory with 1-cycle read latency.
module axi_inst_rd_slave #(
  parameter logic [31:0] ADDR_BASE = 32'h1fc00000,
  parameter int unsigned MEM_AW    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_arvalid,
  output logic              o_arready,
  input  logic [31:0]       i_araddr,
  input  logic [3:0]        i_arid,
  input  logic [3:0]        i_arlen,
  input  logic [2:0]        i_arsize,
  input  logic [1:0]        i_arburst,
  input  logic [1:0]        i_arlock,
  input  logic [3:0]        i_arcache,
  input  logic [2:0]        i_arprot,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic [31:0]       o_rdata,
  output logic [3:0]        o_rid,
  output logic [1:0]        o_rresp,
  output logic              o_rlast,
  output logic              o_mem_en,
  output logic [MEM_AW-1:0] o_mem_addr,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [32:0] WIN_BYTES = 33'(64'(4) << MEM_AW);
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_BEAT} state_t;

  state_t              r_state, w_state_nxt;
  logic [31:0]         r_addr, w_addr_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic [3:0]          r_id, r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic                r_err;
  logic                w_ld;

  logic                r_arready, w_arready_nxt;
  logic                r_rvalid, w_rvalid_nxt;
  logic [31:0]         r_rdata, w_rdata_nxt;
  logic [3:0]          r_rid, w_rid_nxt;
  logic [1:0]          r_rresp, w_rresp_nxt;
  logic                r_rlast, w_rlast_nxt;
  logic                r_mem_en, w_mem_en_nxt;
  logic [MEM_AW-1:0]   r_mem_addr, w_mem_addr_nxt;

  // Error classification of the incoming request, evaluated at the AR handshake
  logic [31:0] w_ar_off;
  logic [32:0] w_ar_step, w_ar_last;
  logic        w_ar_err;

  always_comb begin
    w_ar_off  = i_araddr - ADDR_BASE;
    w_ar_step = 33'(1) << i_arsize;
    w_ar_last = {1'b0, w_ar_off} + 33'(i_arlen) * w_ar_step;
    w_ar_err  = (i_arsize > 3'd2)
              || (i_arburst == 2'b11)
              || ((i_arburst == BURST_WRAP) && !(i_arlen inside {4'd1, 4'd3, 4'd7, 4'd15}))
              || ((i_arburst == BURST_WRAP) && ((i_araddr & (32'(w_ar_step) - 32'd1)) != 32'd0))
              || ({1'b0, w_ar_off} >= WIN_BYTES)
              || ((i_arburst == BURST_INCR) && (w_ar_last >= WIN_BYTES));
  end

  // Next beat address for the latched burst
  logic [31:0] w_step, w_mask, w_next_addr, w_next_off;

  always_comb begin
    w_step = 32'd1 << r_size;
    w_mask = ((32'(r_len) + 32'd1) << r_size) - 32'd1;
    case (r_burst)
      BURST_INCR: w_next_addr = r_addr + w_step;
      BURST_WRAP: w_next_addr = (r_addr & ~w_mask) | ((r_addr + w_step) & w_mask);
      default:    w_next_addr = r_addr;
    endcase
    w_next_off = w_next_addr - ADDR_BASE;
  end

  logic w_unused;
  assign w_unused = ^{i_arlock, i_arcache, i_arprot, w_ar_off[1:0], w_next_off[1:0],
                      w_ar_off[31:MEM_AW+2], w_next_off[31:MEM_AW+2], BURST_FIXED};

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_cnt_nxt      = r_cnt;
    w_ld           = 1'b0;
    w_arready_nxt  = 1'b0;
    w_rvalid_nxt   = r_rvalid;
    w_rdata_nxt    = r_rdata;
    w_rid_nxt      = r_rid;
    w_rresp_nxt    = r_rresp;
    w_rlast_nxt    = r_rlast;
    w_mem_en_nxt   = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    case (r_state)
      S_IDLE: begin
        w_arready_nxt = 1'b1;
        if (i_arvalid && r_arready) begin
          w_ld          = 1'b1;
          w_arready_nxt = 1'b0;
          w_addr_nxt    = i_araddr;
          w_cnt_nxt     = i_arlen;
          w_state_nxt   = S_RD;
          if (!w_ar_err) begin
            w_mem_en_nxt   = 1'b1;
            w_mem_addr_nxt = w_ar_off[MEM_AW+1:2];
          end
        end
      end
      S_RD: w_state_nxt = S_CAP;
      S_CAP: begin
        w_rvalid_nxt = 1'b1;
        w_rdata_nxt  = r_err ? 32'd0 : i_mem_rdata;
        w_rid_nxt    = r_id;
        w_rresp_nxt  = r_err ? RESP_SLVERR : RESP_OKAY;
        w_rlast_nxt  = (r_cnt == 4'd0);
        w_state_nxt  = S_BEAT;
      end
      S_BEAT: begin
        if (r_rvalid && i_rready) begin
          w_rvalid_nxt = 1'b0;
          w_rlast_nxt  = 1'b0;
          if (r_rlast) begin
            w_arready_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_cnt_nxt  = r_cnt - 4'd1;
            w_addr_nxt = w_next_addr;
            // Error bursts never touch memory, so they skip the read cycle
            if (r_err) begin
              w_state_nxt = S_CAP;
            end else begin
              w_state_nxt    = S_RD;
              w_mem_en_nxt   = 1'b1;
              w_mem_addr_nxt = w_next_off[MEM_AW+1:2];
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= 32'd0;
      r_cnt      <= 4'd0;
      r_id       <= 4'd0;
      r_len      <= 4'd0;
      r_size     <= 3'd0;
      r_burst    <= 2'd0;
      r_err      <= 1'b0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= 32'd0;
      r_rid      <= 4'd0;
      r_rresp    <= RESP_OKAY;
      r_rlast    <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_cnt      <= w_cnt_nxt;
      if (w_ld) begin
        r_id    <= i_arid;
        r_len   <= i_arlen;
        r_size  <= i_arsize;
        r_burst <= i_arburst;
        r_err   <= w_ar_err;
      end
      r_arready  <= w_arready_nxt;
      r_rvalid   <= w_rvalid_nxt;
      r_rdata    <= w_rdata_nxt;
      r_rid      <= w_rid_nxt;
      r_rresp    <= w_rresp_nxt;
      r_rlast    <= w_rlast_nxt;
      r_mem_en   <= w_mem_en_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  assign o_arready  = r_arready;
  assign o_rvalid   = r_rvalid;
  assign o_rdata    = r_rdata;
  assign o_rid      = r_rid;
  assign o_rresp    = r_rresp;
  assign o_rlast    = r_rlast;
  assign o_mem_en   = r_mem_en;
  assign o_mem_addr = r_mem_addr;

endmodule
